// File: rtl/ysyx_23060332_csr_unit.sv
// Machine-mode CSR file: mstatus, mtvec, mscratch, mepc, mcause and read-only ID registers.
// Define CSR_MCYCLE_EN to add the free-running 64-bit mcycle/mcycleh counter.
module ysyx_23060332_csr_unit #(
  parameter int          XLEN        = 32,
  parameter logic [63:0] MSTATUS_RST = 64'h1800,
  parameter logic [63:0] MTVEC_RST   = 64'h0,
  parameter logic [63:0] MVENDORID   = 64'h0,
  parameter logic [63:0] MARCHID     = 64'h15fdf1c
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [11:0]     raddr_csr,
  output logic [XLEN-1:0] rdata_csr,
  output logic            csr_illegal,
  input  logic            csr_wen,
  input  logic [11:0]     waddr_csr,
  input  logic [XLEN-1:0] wdata_csr,
  input  logic [1:0]      csr_op,
  input  logic            irq,
  input  logic [XLEN-1:0] irq_cause,
  input  logic            mret,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc,
  output logic            mie_o
);
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [1:0]  OP_WRITE       = 2'b00;
  localparam logic [1:0]  OP_SET         = 2'b01;
  localparam logic [1:0]  OP_CLEAR       = 2'b10;
  localparam logic [1:0]  OP_NONE        = 2'b11;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            mie_reg;
  logic            mpie_reg;
  logic [XLEN-1:0] mtvec_reg;
  logic [XLEN-1:0] mscratch_reg;
  logic [XLEN-1:0] mepc_reg;
  logic [XLEN-1:0] mcause_reg;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN:0]   rd_lookup;
  logic [XLEN:0]   wr_lookup;
  logic [XLEN-1:0] wr_old;
  logic [XLEN-1:0] wr_val;
  logic            wr_en;

`ifdef CSR_MCYCLE_EN
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
  localparam bit          MCYCLEH_OK   = (XLEN == 32);
  logic [63:0]     mcycle_reg;
  logic [63:0]     mcycle_next;
  logic [XLEN-1:0] mcycle_lo;
  logic [XLEN-1:0] mcycle_hi;
`endif

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie_reg;
    mstatus_val[3]     = mie_reg;
  end

  // Returns {illegal, value} for one CSR address; shared by the read port and the RMW path.
  function automatic logic [XLEN:0] lookup(input logic [11:0] addr);
    logic [XLEN-1:0] val;
    logic            ill;
    val = '0;
    ill = 1'b0;
    case (addr)
      ADDR_MSTATUS:   val = mstatus_val;
      ADDR_MTVEC:     val = mtvec_reg;
      ADDR_MSCRATCH:  val = mscratch_reg;
      ADDR_MEPC:      val = mepc_reg;
      ADDR_MCAUSE:    val = mcause_reg;
      ADDR_MVENDORID: val = MVENDORID[XLEN-1:0];
      ADDR_MARCHID:   val = MARCHID[XLEN-1:0];
`ifdef CSR_MCYCLE_EN
      ADDR_MCYCLE:    val = mcycle_lo;
      ADDR_MCYCLEH: begin
        val = mcycle_hi;
        ill = ~MCYCLEH_OK;
      end
`endif
      default:        ill = 1'b1;
    endcase
    return {ill, val};
  endfunction

  always_comb begin
    rd_lookup = lookup(raddr_csr);
    wr_lookup = lookup(waddr_csr);
  end

  assign rdata_csr   = rd_lookup[XLEN-1:0];
  assign csr_illegal = rd_lookup[XLEN];
  assign wr_old      = wr_lookup[XLEN-1:0];

  always_comb begin
    case (csr_op)
      OP_WRITE: wr_val = wdata_csr;
      OP_SET:   wr_val = wr_old | wdata_csr;
      OP_CLEAR: wr_val = wr_old & ~wdata_csr;
      default:  wr_val = wr_old;
    endcase
  end

  // A trap or mret in the same cycle swallows the CSR write.
  assign wr_en = csr_wen && (csr_op != OP_NONE) && !irq && !mret && !wr_lookup[XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_reg      <= MSTATUS_RST[3];
      mpie_reg     <= MSTATUS_RST[7];
      mtvec_reg    <= MTVEC_RST[XLEN-1:0] & ALIGN_MASK;
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
    end else if (irq) begin
      mepc_reg   <= pc & ALIGN_MASK;
      mcause_reg <= irq_cause;
      mpie_reg   <= mie_reg;
      mie_reg    <= 1'b0;
    end else if (mret) begin
      mie_reg  <= mpie_reg;
      mpie_reg <= 1'b1;
    end else if (wr_en) begin
      case (waddr_csr)
        ADDR_MSTATUS: begin
          mie_reg  <= wr_val[3];
          mpie_reg <= wr_val[7];
        end
        ADDR_MTVEC:    mtvec_reg    <= wr_val & ALIGN_MASK;
        ADDR_MSCRATCH: mscratch_reg <= wr_val;
        ADDR_MEPC:     mepc_reg     <= wr_val & ALIGN_MASK;
        ADDR_MCAUSE:   mcause_reg   <= wr_val;
        default: ;
      endcase
    end
  end

`ifdef CSR_MCYCLE_EN
  // A write replaces one half and suppresses that cycle's increment; no carry crosses halves.
  generate
    if (XLEN == 32) begin : g_mcycle32
      assign mcycle_lo = mcycle_reg[31:0];
      assign mcycle_hi = mcycle_reg[63:32];
      always_comb begin
        mcycle_next = mcycle_reg + 64'd1;
        if (wr_en && waddr_csr == ADDR_MCYCLE)
          mcycle_next = {mcycle_reg[63:32], wr_val};
        else if (wr_en && waddr_csr == ADDR_MCYCLEH)
          mcycle_next = {wr_val, mcycle_reg[31:0]};
      end
    end else begin : g_mcycle64
      assign mcycle_lo = mcycle_reg;
      assign mcycle_hi = '0;
      always_comb begin
        mcycle_next = mcycle_reg + 64'd1;
        if (wr_en && waddr_csr == ADDR_MCYCLE)
          mcycle_next = wr_val;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) mcycle_reg <= '0;
    else     mcycle_reg <= mcycle_next;
  end
`endif

  assign mtvec = mtvec_reg;
  assign mepc  = mepc_reg;
  assign mie_o = mie_reg;
endmodule

// File: tb/tb_ysyx_23060332_csr_unit.sv
// Bench for ysyx_23060332_csr_unit (XLEN=32): directed vector table, corner sequences,
// then random traffic against a value-level CSR model. Honours CSR_MCYCLE_EN.
module tb_ysyx_23060332_csr_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [11:0] raddr_csr;
  logic [31:0] rdata_csr;
  logic        csr_illegal;
  logic        csr_wen;
  logic [11:0] waddr_csr;
  logic [31:0] wdata_csr;
  logic [1:0]  csr_op;
  logic        irq;
  logic [31:0] irq_cause;
  logic        mret;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie_o;

  ysyx_23060332_csr_unit dut (
    .clk(clk), .rst(rst), .pc(pc), .raddr_csr(raddr_csr), .rdata_csr(rdata_csr),
    .csr_illegal(csr_illegal), .csr_wen(csr_wen), .waddr_csr(waddr_csr),
    .wdata_csr(wdata_csr), .csr_op(csr_op), .irq(irq), .irq_cause(irq_cause),
    .mret(mret), .mtvec(mtvec), .mepc(mepc), .mie_o(mie_o)
  );

  always #5 clk = ~clk;

`ifdef CSR_MCYCLE_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: the architectural value of every CSR as software sees it.
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle;

  logic [11:0] addrs [12] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF11,
                              12'hF12, 12'hB00, 12'hB80, 12'h7C0, 12'h301, 12'h000};

  function automatic logic [32:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b0, m_mstatus};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'hF11: return {1'b0, 32'h0};
      12'hF12: return {1'b0, 32'h015fdf1c};
      12'hB00: return MC_EN ? {1'b0, m_cycle[31:0]} : {1'b1, 32'h0};
      12'hB80: return MC_EN ? {1'b0, m_cycle[63:32]} : {1'b1, 32'h0};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic model_update();
    logic [32:0] old;
    logic [31:0] v;
    logic        wr;
    old = model_read(waddr_csr);
    case (csr_op)
      2'b00:   v = wdata_csr;
      2'b01:   v = old[31:0] | wdata_csr;
      2'b10:   v = old[31:0] & ~wdata_csr;
      default: v = old[31:0];
    endcase
    wr = csr_wen && csr_op != 2'b11 && !irq && !mret && !old[32];
    if (rst) begin
      m_mstatus = 32'h1800; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0;
    end else begin
      if (irq) begin
        m_mepc    = pc & ~32'h3;
        m_mcause  = irq_cause;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (mret) begin
        m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (wr) begin
        case (waddr_csr)
          12'h300: m_mstatus  = (v & 32'h88) | 32'h1800;
          12'h305: m_mtvec    = v & ~32'h3;
          12'h340: m_mscratch = v;
          12'h341: m_mepc     = v & ~32'h3;
          12'h342: m_mcause   = v;
          default: ;
        endcase
      end
      if (wr && waddr_csr == 12'hB00)      m_cycle[31:0]  = v;
      else if (wr && waddr_csr == 12'hB80) m_cycle[63:32] = v;
      else                                 m_cycle        = m_cycle + 64'd1;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_wen = 0; csr_op = 2'b11; waddr_csr = 0; wdata_csr = 0;
    irq = 0; mret = 0; pc = 0; irq_cause = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [11:0] a,
                            input logic [31:0] exp, input logic exp_ill);
    raddr_csr = a;
    #1;
    check({name, " rdata"}, rdata_csr, exp);
    check({name, " illegal"}, 32'(csr_illegal), 32'(exp_ill));
  endtask

  task automatic check_model(input string name);
    logic [32:0] r;
    r = model_read(raddr_csr);
    check({name, " rdata"}, rdata_csr, r[31:0]);
    check({name, " illegal"}, 32'(csr_illegal), 32'(r[32]));
    check({name, " mtvec"}, mtvec, m_mtvec);
    check({name, " mepc"}, mepc, m_mepc);
    check({name, " mie_o"}, 32'(mie_o), 32'(m_mstatus[3]));
  endtask

  typedef struct packed {
    logic        wen;
    logic [1:0]  op;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] cause;
    logic        mret;
    logic [11:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_ill;
    logic        exp_mie;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic wen, input logic [1:0] op, input logic [11:0] wa,
                              input logic [31:0] wd, input logic iq, input logic [31:0] p,
                              input logic [31:0] c, input logic mr, input logic [11:0] ra,
                              input logic [31:0] er, input logic ei, input logic em);
    vec_t t;
    t = '{wen: wen, op: op, waddr: wa, wdata: wd, irq: iq, pc: p, cause: c, mret: mr,
          raddr: ra, exp_rdata: er, exp_ill: ei, exp_mie: em};
    return t;
  endfunction

  initial begin
    vecs[0]  = mk(0, 2'b11, 12'h000, 32'h0,        0, 0, 0, 0, 12'h300, 32'h1800,     0, 0);
    vecs[1]  = mk(0, 2'b11, 12'h000, 32'h0,        0, 0, 0, 0, 12'h305, 32'h0,        0, 0);
    vecs[2]  = mk(0, 2'b11, 12'h000, 32'h0,        0, 0, 0, 0, 12'h7C0, 32'h0,        1, 0);
    vecs[3]  = mk(1, 2'b00, 12'h305, 32'h80000007, 0, 0, 0, 0, 12'h305, 32'h80000004, 0, 0);
    vecs[4]  = mk(1, 2'b00, 12'h340, 32'hF0,       0, 0, 0, 0, 12'h340, 32'hF0,       0, 0);
    vecs[5]  = mk(1, 2'b01, 12'h340, 32'h0F,       0, 0, 0, 0, 12'h340, 32'hFF,       0, 0);
    vecs[6]  = mk(1, 2'b10, 12'h340, 32'h0F,       0, 0, 0, 0, 12'h340, 32'hF0,       0, 0);
    vecs[7]  = mk(1, 2'b11, 12'h340, 32'h12345678, 0, 0, 0, 0, 12'h340, 32'hF0,       0, 0);
    vecs[8]  = mk(1, 2'b01, 12'h300, 32'h8,        0, 0, 0, 0, 12'h300, 32'h1808,     0, 1);
    vecs[9]  = mk(0, 2'b11, 12'h000, 32'h0,        1, 32'h80000102, 32'hB, 0, 12'h341, 32'h80000100, 0, 0);
    vecs[10] = mk(0, 2'b11, 12'h000, 32'h0,        0, 0, 0, 0, 12'h342, 32'hB,        0, 0);
    vecs[11] = mk(0, 2'b11, 12'h000, 32'h0,        0, 0, 0, 0, 12'h300, 32'h1880,     0, 0);
    vecs[12] = mk(0, 2'b11, 12'h000, 32'h0,        0, 0, 0, 1, 12'h300, 32'h1888,     0, 1);
    vecs[13] = mk(1, 2'b00, 12'hF11, 32'hFFFFFFFF, 0, 0, 0, 0, 12'hF11, 32'h0,        0, 1);
    vecs[14] = mk(1, 2'b00, 12'hF12, 32'h0,        0, 0, 0, 0, 12'hF12, 32'h015fdf1c, 0, 1);
    vecs[15] = mk(1, 2'b00, 12'h300, 32'hFFFFFFFF, 0, 0, 0, 0, 12'h300, 32'h1888,     0, 1);
    vecs[16] = mk(1, 2'b00, 12'h300, 32'h0,        0, 0, 0, 0, 12'h300, 32'h1800,     0, 0);
    vecs[17] = mk(1, 2'b00, 12'h341, 32'h12345677, 0, 0, 0, 0, 12'h341, 32'h12345674, 0, 0);
    vecs[18] = mk(1, 2'b00, 12'h7C0, 32'h1,        0, 0, 0, 0, 12'h7C0, 32'h0,        1, 0);

    idle();
    raddr_csr = 12'h300;
    rst = 1;
    tick();
    tick();
    rst = 0;
    read_check("reset mstatus", 12'h300, 32'h1800, 0);
    check("reset mie_o", 32'(mie_o), 32'h0);
    check("reset mtvec", mtvec, 32'h0);

    for (int i = 0; i < NV; i++) begin
      csr_wen = vecs[i].wen; csr_op = vecs[i].op; waddr_csr = vecs[i].waddr;
      wdata_csr = vecs[i].wdata; irq = vecs[i].irq; pc = vecs[i].pc;
      irq_cause = vecs[i].cause; mret = vecs[i].mret;
      tick();
      idle();
      read_check($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp_rdata, vecs[i].exp_ill);
      check($sformatf("vec%0d mie_o", i), 32'(mie_o), 32'(vecs[i].exp_mie));
    end
    check("table mtvec out", mtvec, 32'h80000004);

    // Same-cycle read sees the pre-write value.
    raddr_csr = 12'h340; csr_wen = 1; csr_op = 2'b00; waddr_csr = 12'h340; wdata_csr = 32'h55;
    #1;
    check("same-cycle old", rdata_csr, 32'hF0);
    tick();
    idle();
    read_check("write landed", 12'h340, 32'h55, 0);

    // irq + mret + write together: only the trap lands.
    csr_wen = 1; csr_op = 2'b01; waddr_csr = 12'h300; wdata_csr = 32'h8;
    tick();
    irq = 1; pc = 32'h103; irq_cause = 32'h3; mret = 1;
    csr_wen = 1; csr_op = 2'b00; waddr_csr = 12'h340; wdata_csr = 32'hAAAA;
    tick();
    idle();
    check("prio mepc", mepc, 32'h100);
    read_check("prio mcause", 12'h342, 32'h3, 0);
    read_check("prio mstatus", 12'h300, 32'h1880, 0);
    read_check("prio mscratch", 12'h340, 32'h55, 0);
    mret = 1; csr_wen = 1; csr_op = 2'b00; waddr_csr = 12'h340; wdata_csr = 32'hBBBB;
    tick();
    idle();
    read_check("mret mstatus", 12'h300, 32'h1888, 0);
    read_check("mret drops write", 12'h340, 32'h55, 0);
    check("mret mie_o", 32'(mie_o), 32'h1);

    // Reset arriving together with a trap.
    rst = 1; irq = 1; pc = 32'h200; irq_cause = 32'h7;
    tick();
    rst = 0;
    idle();
    check("rst-trap mepc", mepc, 32'h0);
    check("rst-trap mie_o", 32'(mie_o), 32'h0);
    read_check("rst-trap mcause", 12'h342, 32'h0, 0);
    read_check("rst-trap mstatus", 12'h300, 32'h1800, 0);
    read_check("rst-trap mscratch", 12'h340, 32'h0, 0);

    if (MC_EN) begin
      csr_wen = 1; csr_op = 2'b00; waddr_csr = 12'hB00; wdata_csr = 32'hFFFFFFFE;
      tick();
      idle();
      read_check("mcycle written", 12'hB00, 32'hFFFFFFFE, 0);
      tick();
      read_check("mcycle +1", 12'hB00, 32'hFFFFFFFF, 0);
      tick();
      read_check("mcycle wrap", 12'hB00, 32'h0, 0);
      read_check("mcycleh carry", 12'hB80, 32'h1, 0);
      rst = 1;
      tick();
      rst = 0;
      read_check("mcycle rst", 12'hB00, 32'h0, 0);
      read_check("mcycleh rst", 12'hB80, 32'h0, 0);
      tick();
      read_check("mcycle resume", 12'hB00, 32'h1, 0);
      csr_wen = 1; csr_op = 2'b00; waddr_csr = 12'hB80; wdata_csr = 32'h5;
      tick();
      idle();
      read_check("mcycleh write", 12'hB80, 32'h5, 0);
      read_check("mcycle held", 12'hB00, 32'h1, 0);
      tick();
      read_check("mcycle after hold", 12'hB00, 32'h2, 0);
    end else begin
      read_check("no mcycle", 12'hB00, 32'h0, 1);
      read_check("no mcycleh", 12'hB80, 32'h0, 1);
    end

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      irq       = ($urandom_range(0, 9) == 0);
      mret      = ($urandom_range(0, 9) == 0);
      csr_wen   = ($urandom_range(0, 1) == 1);
      csr_op    = 2'($urandom_range(0, 3));
      waddr_csr = addrs[$urandom_range(0, 11)];
      raddr_csr = addrs[$urandom_range(0, 11)];
      wdata_csr = $urandom;
      pc        = $urandom;
      irq_cause = $urandom;
      #1;
      check_model($sformatf("rand%0d", i));
      tick();
    end
    rst = 0;
    idle();
    raddr_csr = 12'h300;
    #1;
    check_model("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
